// File: rtl/fft_frame_arbiter.sv
// Two-requester frame arbiter in front of a streaming FFT core: grants whole
// frames round-robin, issues the per-frame direction config and tags core output with its owner.
module fft_frame_arbiter #(
    parameter int DIN_W        = 32,
    parameter int DOUT_W       = 32,
    parameter int USER_W       = 24,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic              i_aclk,
    input  logic              i_rst,

    input  logic              i_s0_tvalid,
    input  logic [DIN_W-1:0]  i_s0_tdata,
    input  logic              i_s0_tlast,
    output logic              o_s0_tready,
    input  logic              i_s0_inv,

    input  logic              i_s1_tvalid,
    input  logic [DIN_W-1:0]  i_s1_tdata,
    input  logic              i_s1_tlast,
    output logic              o_s1_tready,
    input  logic              i_s1_inv,

    output logic              o_xn_tvalid,
    output logic [DIN_W-1:0]  o_xn_tdata,
    output logic              o_xn_tlast,
    input  logic              i_xn_tready,

    output logic              o_cfg_tvalid,
    output logic              o_cfg_tdata,

    input  logic              i_xk_tvalid,
    input  logic [DOUT_W-1:0] i_xk_tdata,
    input  logic              i_xk_tlast,
    input  logic [USER_W-1:0] i_xk_tuser,

    output logic              o_m_tvalid,
    output logic [DOUT_W-1:0] o_m_tdata,
    output logic              o_m_tlast,
    output logic [USER_W-1:0] o_m_tuser,
    output logic              o_m_tid,

    input  logic [2:0]        i_alm,
    input  logic              i_err_clr,

    output logic              o_err_alm,
    output logic              o_err_orphan,
    output logic              o_busy,
    output logic [2:0]        o_inflight
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CFG    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [2:0] MAX_CNT  = 3'(MAX_INFLIGHT);
    localparam logic [1:0] PTR_LAST = 2'(MAX_INFLIGHT - 1);

    logic [1:0] state;
    logic       rr_ptr;
    logic       grant_idx;
    logic       inv_q;
    logic [2:0] inflight;

    logic [3:0] tag_mem;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    logic any_req;
    logic can_grant;
    logic next_grant;
    logic in_stream;
    logic fifo_empty;
    logic frame_done;
    logic tag_push;
    logic tag_pop;
    logic orphan_hit;
    logic alm_hit;

    assign any_req    = i_s0_tvalid | i_s1_tvalid;
    assign in_stream  = (state == ST_STREAM);
    assign fifo_empty = (inflight == 3'd0);
    assign can_grant  = (state == ST_IDLE) && (inflight < MAX_CNT) && any_req;
    // Pointer side wins when it is requesting, otherwise the other side.
    assign next_grant = rr_ptr ? i_s1_tvalid : ~i_s0_tvalid;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        o_xn_tvalid = 1'b0;
        o_xn_tdata  = '0;
        o_xn_tlast  = 1'b0;
        o_s0_tready = 1'b0;
        o_s1_tready = 1'b0;
        if (in_stream) begin
            if (grant_idx) begin
                o_xn_tvalid = i_s1_tvalid;
                o_xn_tdata  = i_s1_tdata;
                o_xn_tlast  = i_s1_tlast;
                o_s1_tready = i_xn_tready;
            end else begin
                o_xn_tvalid = i_s0_tvalid;
                o_xn_tdata  = i_s0_tdata;
                o_xn_tlast  = i_s0_tlast;
                o_s0_tready = i_xn_tready;
            end
        end
    end

    assign frame_done = o_xn_tvalid & i_xn_tready & o_xn_tlast;
    assign tag_push   = frame_done;
    assign tag_pop    = i_xk_tvalid & i_xk_tlast & ~fifo_empty;
    assign orphan_hit = i_xk_tvalid & fifo_empty;
    assign alm_hit    = |i_alm;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            grant_idx <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_grant) begin
                        grant_idx <= next_grant;
                        inv_q     <= next_grant ? i_s1_inv : i_s0_inv;
                        state     <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (frame_done) begin
                        rr_ptr <= ~grant_idx;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: tag storage has no reset; entries are only read between the pointers.
    always_ff @(posedge i_aclk) begin
        if (tag_push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            inflight <= 3'd0;
        end else begin
            if (tag_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (tag_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({tag_push, tag_pop})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Output beat and its owner tag are captured together so the tid stays
    // aligned with the tlast beat that pops the FIFO.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_m_tvalid <= 1'b0;
            o_m_tdata  <= '0;
            o_m_tlast  <= 1'b0;
            o_m_tuser  <= '0;
            o_m_tid    <= 1'b0;
        end else begin
            o_m_tvalid <= i_xk_tvalid;
            o_m_tdata  <= i_xk_tdata;
            o_m_tlast  <= i_xk_tlast;
            o_m_tuser  <= i_xk_tuser;
            o_m_tid    <= fifo_empty ? 1'b0 : tag_mem[rd_ptr];
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            o_err_alm    <= 1'b0;
            o_err_orphan <= 1'b0;
        end else begin
            if (alm_hit) begin
                o_err_alm <= 1'b1;
            end else if (i_err_clr) begin
                o_err_alm <= 1'b0;
            end
            if (orphan_hit) begin
                o_err_orphan <= 1'b1;
            end else if (i_err_clr) begin
                o_err_orphan <= 1'b0;
            end
        end
    end

    assign o_cfg_tvalid = (state == ST_CFG);
    assign o_cfg_tdata  = (state == ST_CFG) & inv_q;
    assign o_busy       = (state != ST_IDLE) || !fifo_empty;
    assign o_inflight   = inflight;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Randomized bench for fft_frame_arbiter against a frame-level reference model
// (grant rule, tag queue, sticky flags) evaluated on the falling clock edge.
module tb_fft_frame_arbiter;

    localparam int DIN_W        = 32;
    localparam int DOUT_W       = 32;
    localparam int USER_W       = 24;
    localparam int MAX_INFLIGHT = 2;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              s_valid [2];
    logic [DIN_W-1:0]  s_tdata [2];
    logic              s_tlast [2];
    logic              s_inv   [2];
    logic              o_s0_tready, o_s1_tready;
    logic              o_xn_tvalid, o_xn_tlast, xn_tready;
    logic [DIN_W-1:0]  o_xn_tdata;
    logic              o_cfg_tvalid, o_cfg_tdata;
    logic              xk_valid, xk_last;
    logic [DOUT_W-1:0] xk_data;
    logic [USER_W-1:0] xk_user;
    logic              o_m_tvalid, o_m_tlast, o_m_tid;
    logic [DOUT_W-1:0] o_m_tdata;
    logic [USER_W-1:0] o_m_tuser;
    logic [2:0]        i_alm;
    logic              i_err_clr;
    logic              o_err_alm, o_err_orphan, o_busy;
    logic [2:0]        o_inflight;

    fft_frame_arbiter #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .USER_W(USER_W), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .i_aclk(clk), .i_rst(i_rst),
        .i_s0_tvalid(s_valid[0]), .i_s0_tdata(s_tdata[0]), .i_s0_tlast(s_tlast[0]),
        .o_s0_tready(o_s0_tready), .i_s0_inv(s_inv[0]),
        .i_s1_tvalid(s_valid[1]), .i_s1_tdata(s_tdata[1]), .i_s1_tlast(s_tlast[1]),
        .o_s1_tready(o_s1_tready), .i_s1_inv(s_inv[1]),
        .o_xn_tvalid(o_xn_tvalid), .o_xn_tdata(o_xn_tdata), .o_xn_tlast(o_xn_tlast),
        .i_xn_tready(xn_tready),
        .o_cfg_tvalid(o_cfg_tvalid), .o_cfg_tdata(o_cfg_tdata),
        .i_xk_tvalid(xk_valid), .i_xk_tdata(xk_data), .i_xk_tlast(xk_last), .i_xk_tuser(xk_user),
        .o_m_tvalid(o_m_tvalid), .o_m_tdata(o_m_tdata), .o_m_tlast(o_m_tlast),
        .o_m_tuser(o_m_tuser), .o_m_tid(o_m_tid),
        .i_alm(i_alm), .i_err_clr(i_err_clr),
        .o_err_alm(o_err_alm), .o_err_orphan(o_err_orphan), .o_busy(o_busy),
        .o_inflight(o_inflight)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: which phase the frame handshake is in, owner queue, flags.
    typedef enum int {P_IDLE, P_CFG, P_STREAM} phase_t;
    phase_t m_phase = P_IDLE;
    bit     m_rr = 1'b0, m_owner = 1'b0, m_inv = 1'b0;
    bit     m_tags[$];
    bit     m_err_alm = 1'b0, m_err_orph = 1'b0;
    logic              r_valid = 1'b0, r_last = 1'b0, r_tid = 1'b0;
    logic [DOUT_W-1:0] r_data = '0;
    logic [USER_W-1:0] r_user = '0;

    // Stimulus state and knobs.
    int  frames_left [2];
    int  beat_left   [2];
    int  xk_left = 0;
    int  ready_pct = 100;
    bit  core_en = 1'b1, stop_feed = 1'b0, inv_rand = 1'b1, clr_rand = 1'b0, alm_rand = 1'b0;
    int  cyc = 0, pushpop_seen = 0;
    int  first_pop_cyc = -1, first_cfg_cyc = -1;
    bit  track_release = 1'b0;
    bit  tid_log[$];

    task automatic drive(input bit hs0, input bit hs1);
        for (int n = 0; n < 2; n++) begin
            if ((n == 0) ? hs0 : hs1) begin
                if (s_tlast[n]) begin
                    if (frames_left[n] > 0) frames_left[n]--;
                    if (stop_feed) frames_left[n] = 0;
                    beat_left[n] = $urandom_range(1, 4);
                end else begin
                    beat_left[n]--;
                end
                s_tdata[n] = $urandom;
            end
            s_valid[n] = (frames_left[n] > 0);
            s_tlast[n] = (beat_left[n] == 1);
            if (inv_rand) s_inv[n] = 1'($urandom_range(0, 1));
        end
        xn_tready = ($urandom_range(0, 99) < ready_pct);
        if (xk_valid && xk_left > 0) begin
            if (xk_last) xk_left = 0;
            else         xk_left--;
        end
        if (i_rst) xk_left = 0;
        if (xk_left == 0 && core_en && m_tags.size() > 0) xk_left = $urandom_range(1, 3);
        xk_valid  = (xk_left > 0) && ($urandom_range(0, 3) != 0);
        xk_last   = (xk_left == 1);
        xk_data   = $urandom;
        xk_user   = USER_W'($urandom);
        i_rst     = 1'b0;
        i_err_clr = clr_rand ? ($urandom_range(0, 39) == 0) : 1'b0;
        i_alm     = (alm_rand && $urandom_range(0, 99) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    endtask

    task automatic step();
        int cnt_now;
        bit hs0, hs1, done, pop, orph, g;
        @(negedge clk);
        cyc++;
        cnt_now = m_tags.size();
        check("inflight", o_inflight, 64'(cnt_now));
        check("busy", o_busy, (m_phase != P_IDLE) || (cnt_now != 0));
        check("cfg_valid", o_cfg_tvalid, m_phase == P_CFG);
        check("cfg_data", o_cfg_tdata, (m_phase == P_CFG) ? m_inv : 1'b0);
        if (m_phase == P_STREAM) begin
            check("xn_valid", o_xn_tvalid, s_valid[m_owner]);
            check("xn_data", o_xn_tdata, s_tdata[m_owner]);
            check("xn_last", o_xn_tlast, s_tlast[m_owner]);
            check("rdy_owner", m_owner ? o_s1_tready : o_s0_tready, xn_tready);
            check("rdy_other", m_owner ? o_s0_tready : o_s1_tready, 1'b0);
        end else begin
            check("xn_quiet", {o_xn_tvalid, o_s0_tready, o_s1_tready}, 3'b000);
        end
        check("m_valid", o_m_tvalid, r_valid);
        check("m_data", o_m_tdata, r_data);
        check("m_last", o_m_tlast, r_last);
        check("m_user", o_m_tuser, r_user);
        check("m_tid", o_m_tid, r_tid);
        check("err_alm", o_err_alm, m_err_alm);
        check("err_orphan", o_err_orphan, m_err_orph);
        if (o_m_tvalid && o_m_tlast) tid_log.push_back(o_m_tid);
        if (track_release && first_pop_cyc < 0 && xk_valid && xk_last) first_pop_cyc = cyc;
        if (track_release && first_cfg_cyc < 0 && o_cfg_tvalid) first_cfg_cyc = cyc;

        hs0  = s_valid[0] & o_s0_tready;
        hs1  = s_valid[1] & o_s1_tready;
        done = (m_phase == P_STREAM) && s_valid[m_owner] && xn_tready && s_tlast[m_owner];
        pop  = xk_valid && xk_last && (cnt_now != 0);
        orph = xk_valid && (cnt_now == 0);
        if (i_rst) begin
            m_tags.delete();
            m_phase = P_IDLE; m_rr = 1'b0; m_owner = 1'b0; m_inv = 1'b0;
            m_err_alm = 1'b0; m_err_orph = 1'b0;
            r_valid = 1'b0; r_last = 1'b0; r_tid = 1'b0; r_data = '0; r_user = '0;
        end else begin
            r_valid = xk_valid; r_last = xk_last; r_data = xk_data; r_user = xk_user;
            r_tid   = (cnt_now != 0) ? m_tags[0] : 1'b0;
            if (|i_alm) m_err_alm = 1'b1;
            else if (i_err_clr) m_err_alm = 1'b0;
            if (orph) m_err_orph = 1'b1;
            else if (i_err_clr) m_err_orph = 1'b0;
            if (pop) void'(m_tags.pop_front());
            if (done) m_tags.push_back(m_owner);
            if (pop && done) pushpop_seen++;
            case (m_phase)
                P_IDLE: if (cnt_now < MAX_INFLIGHT && (s_valid[0] || s_valid[1])) begin
                    g = m_rr ? (s_valid[1] ? 1'b1 : 1'b0) : (s_valid[0] ? 1'b0 : 1'b1);
                    m_owner = g;
                    m_inv   = s_inv[g];
                    m_phase = P_CFG;
                end
                P_CFG:    m_phase = P_STREAM;
                default:  if (done) begin m_rr = ~m_owner; m_phase = P_IDLE; end
            endcase
        end
        @(posedge clk);
        #1;
        drive(hs0, hs1);
    endtask

    initial begin
        int guard;
        i_rst = 1'b1; i_alm = 3'b000; i_err_clr = 1'b0; xn_tready = 1'b1;
        xk_valid = 1'b0; xk_last = 1'b0; xk_data = '0; xk_user = '0;
        for (int n = 0; n < 2; n++) begin
            frames_left[n] = 1;
            beat_left[n]   = $urandom_range(1, 4);
            s_valid[n]     = 1'b1;
            s_tdata[n]     = $urandom;
            s_tlast[n]     = (beat_left[n] == 1);
            s_inv[n]       = 1'($urandom_range(0, 1));
        end
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Both requesters valid at reset release: s0 first, then s1.
        guard = 0;
        while (guard < 300 && !(tid_log.size() >= 2 && m_tags.size() == 0 && m_phase == P_IDLE)) begin
            step();
            guard++;
        end
        check("boot_frames_out", 64'(tid_log.size()), 64'd2);
        if (tid_log.size() >= 2) begin
            check("boot_tid0", tid_log[0], 1'b0);
            check("boot_tid1", tid_log[1], 1'b1);
        end

        // Core output stalled: two frames in flight, the third is held off.
        core_en = 1'b0;
        frames_left[0] = 10;
        frames_left[1] = 10;
        repeat (80) step();
        check("stall_inflight", o_inflight, 3'd2);
        check("stall_ready", {o_s0_tready, o_s1_tready}, 2'b00);
        check("stall_no_cfg", o_cfg_tvalid, 1'b0);
        track_release = 1'b1;
        core_en = 1'b1;
        guard = 0;
        while (guard < 100 && first_cfg_cyc < 0) begin
            step();
            guard++;
        end
        track_release = 1'b0;
        check("release_seen", first_cfg_cyc >= 0 && first_pop_cyc >= 0, 1'b1);
        check("release_latency", (first_cfg_cyc > first_pop_cyc) && (first_cfg_cyc - first_pop_cyc <= 2), 1'b1);

        // Randomized traffic with backpressure, core stalls, alarms and clears.
        frames_left[0] = 100000;
        frames_left[1] = 100000;
        ready_pct = 70; clr_rand = 1'b1; alm_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) core_en = ($urandom_range(0, 3) != 0);
            step();
        end
        core_en = 1'b1; clr_rand = 1'b0; alm_rand = 1'b0;
        check("push_pop_same_cycle_hit", pushpop_seen > 0, 1'b1);

        // Drain everything, then exercise the sticky error flags.
        stop_feed = 1'b1;
        guard = 0;
        while (guard < 600 && !(m_tags.size() == 0 && m_phase == P_IDLE && !s_valid[0] && !s_valid[1] && xk_left == 0)) begin
            step();
            guard++;
        end
        check("drain_done", m_tags.size() == 0 && m_phase == P_IDLE, 1'b1);
        i_err_clr = 1'b1; step();
        check("clr_alm", o_err_alm, 1'b0);
        check("clr_orphan", o_err_orphan, 1'b0);
        xk_valid = 1'b1; xk_last = 1'b0; step();
        check("orphan_set", o_err_orphan, 1'b1);
        check("orphan_fwd_valid", o_m_tvalid, 1'b1);
        check("orphan_tid", o_m_tid, 1'b0);
        i_err_clr = 1'b1; step();
        check("orphan_clr", o_err_orphan, 1'b0);
        i_alm = 3'b010; step();
        check("alm_set", o_err_alm, 1'b1);
        i_alm = 3'b001; i_err_clr = 1'b1; step();
        check("alm_set_beats_clr", o_err_alm, 1'b1);
        i_err_clr = 1'b1; step();
        check("alm_clr", o_err_alm, 1'b0);
        xk_valid = 1'b1; i_err_clr = 1'b1; step();
        check("orphan_set_beats_clr", o_err_orphan, 1'b1);
        i_err_clr = 1'b1; step();

        // Fixed directions: each cfg word must carry its own requester's inv.
        stop_feed = 1'b0; inv_rand = 1'b0; ready_pct = 100;
        s_inv[0] = 1'b0; s_inv[1] = 1'b1;
        frames_left[0] = 6;
        frames_left[1] = 6;
        repeat (150) step();

        // Reset mid-frame, then the next grant must start from requester 0.
        inv_rand = 1'b1; ready_pct = 60;
        frames_left[0] = 100000;
        frames_left[1] = 100000;
        guard = 0;
        while (guard < 300 && !(cyc >= 100 && m_phase == P_STREAM)) begin
            step();
            guard++;
        end
        check("reached_stream", m_phase == P_STREAM, 1'b1);
        i_rst = 1'b1; step();
        check("rst_xn_valid", o_xn_tvalid, 1'b0);
        check("rst_ready", {o_s0_tready, o_s1_tready}, 2'b00);
        check("rst_cfg", o_cfg_tvalid, 1'b0);
        check("rst_inflight", o_inflight, 3'd0);
        check("rst_m_valid", o_m_tvalid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        xn_tready = 1'b1; ready_pct = 100;
        guard = 0;
        while (guard < 20 && !(o_s0_tready || o_s1_tready)) begin
            step();
            guard++;
        end
        check("post_rst_grant_seen", o_s0_tready | o_s1_tready, 1'b1);
        check("post_rst_grant_s1", o_s1_tready, 1'b0);
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
